hbm_strided_read_master: RTL and testbench

//  AXI4 read master that fetches a 2-D region from HBM: ctrl_num_rows rows of ctrl_row_bytes each,
//  row r starting at ctrl_addr + r*ctrl_stride. Emits the data as AXI4-Stream with tlast on each row's

---
 rtl/hbm_strided_read_master.sv | 193 +++++++++++++++++++
 tb/tb_hbm_strided_read_master.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hbm_strided_read_master.sv
// Strided 2-D AXI4 read master: each row is fetched as bursts split at C_BURST_LEN and 4 KB,
// and streamed out with tlast on the row's final beat. Busy/stall counters exist only under HBM_RD_PERF_CNT_EN.
module hbm_strided_read_master #(
  parameter int C_M_AXI_ADDR_WIDTH = 64,
  parameter int C_M_AXI_DATA_WIDTH = 512,
  parameter int C_BURST_LEN        = 64,
  parameter int C_MAX_OUTSTANDING  = 16,
  parameter int C_ROWS_WIDTH       = 16
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic                          ctrl_start,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] ctrl_addr,
  input  logic [31:0]                   ctrl_row_bytes,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] ctrl_stride,
  input  logic [C_ROWS_WIDTH-1:0]       ctrl_num_rows,
  output logic                          ctrl_busy,
  output logic                          ctrl_done,
  output logic                          ctrl_err,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]                    m_axi_arlen,
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]                    m_axi_rresp,
  input  logic                          m_axi_rlast,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [C_M_AXI_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                          m_axis_tlast,
  output logic [31:0]                   stat_cycles,
  output logic [31:0]                   stat_stalls
);

  localparam int AW      = C_M_AXI_ADDR_WIDTH;
  localparam int RW      = C_ROWS_WIDTH;
  localparam int DWB     = C_M_AXI_DATA_WIDTH / 8;
  localparam int LOG_DWB = $clog2(DWB);
  localparam int OUT_W   = $clog2(C_MAX_OUTSTANDING + 1);
  localparam logic [AW-1:0] ADDR_MASK = ~AW'(DWB - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_CALC, S_ISSUE, S_NEXT_ROW, S_DRAIN, S_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [AW-1:0]    row_base, addr, stride_r;
  logic [31:0]      row_beats, beats_left, beat_cnt;
  logic [RW-1:0]    rows_left;
  logic [8:0]       len, len_calc;
  logic [12:0]      page_beats;
  logic [OUT_W-1:0] outstanding;
  logic             err_r;
  logic             start_ok, ar_hs, r_hs, rlast_hs;

  assign start_ok = ctrl_start && (state == S_IDLE || state == S_DONE);
  assign ar_hs    = m_axi_arvalid && m_axi_arready;
  assign r_hs     = m_axi_rvalid && m_axi_rready;
  assign rlast_hs = r_hs && m_axi_rlast;

  // Beats remaining before the next 4 KB boundary; addr is always beat-aligned.
  assign page_beats = (13'h1000 - {1'b0, addr[11:0]}) >> LOG_DWB;

  always_comb begin
    len_calc = 9'(C_BURST_LEN);
    if (32'(page_beats) < 32'(len_calc)) len_calc = page_beats[8:0];
    if (beats_left < 32'(len_calc))      len_calc = beats_left[8:0];
  end

  always_ff @(posedge aclk) begin
    if (areset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    m_axi_arvalid = 1'b0;
    ctrl_busy     = 1'b0;
    ctrl_done     = 1'b0;
    case (state)
      S_IDLE:  if (ctrl_start) state_nxt = S_SETUP;
      S_SETUP: begin
        ctrl_busy = 1'b1;
        if (row_beats == 32'd0 || rows_left == '0) state_nxt = S_DRAIN;
        else                                       state_nxt = S_CALC;
      end
      S_CALC: begin
        ctrl_busy = 1'b1;
        if (outstanding != OUT_W'(C_MAX_OUTSTANDING)) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        ctrl_busy     = 1'b1;
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) begin
          if (beats_left != 32'(len))     state_nxt = S_CALC;
          else if (rows_left != RW'(1))   state_nxt = S_NEXT_ROW;
          else                            state_nxt = S_DRAIN;
        end
      end
      S_NEXT_ROW: begin
        ctrl_busy = 1'b1;
        state_nxt = S_CALC;
      end
      // Every burst ends in rlast, so a zero count means all beats have arrived.
      S_DRAIN: begin
        ctrl_busy = 1'b1;
        if (outstanding == '0) begin
          ctrl_done = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = ctrl_start ? S_SETUP : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      row_base    <= '0;
      addr        <= '0;
      stride_r    <= '0;
      row_beats   <= '0;
      beats_left  <= '0;
      rows_left   <= '0;
      len         <= '0;
      outstanding <= '0;
      beat_cnt    <= '0;
      err_r       <= 1'b0;
    end else begin
      if (start_ok) begin
        row_base   <= ctrl_addr & ADDR_MASK;
        addr       <= ctrl_addr & ADDR_MASK;
        stride_r   <= ctrl_stride & ADDR_MASK;
        row_beats  <= 32'(ctrl_row_bytes[31:LOG_DWB]) + 32'(|ctrl_row_bytes[LOG_DWB-1:0]);
        beats_left <= 32'(ctrl_row_bytes[31:LOG_DWB]) + 32'(|ctrl_row_bytes[LOG_DWB-1:0]);
        rows_left  <= ctrl_num_rows;
      end else if (ar_hs) begin
        addr       <= addr + (AW'(len) << LOG_DWB);
        beats_left <= beats_left - 32'(len);
      end else if (state == S_NEXT_ROW) begin
        row_base   <= row_base + stride_r;
        addr       <= row_base + stride_r;
        beats_left <= row_beats;
        rows_left  <= rows_left - RW'(1);
      end

      if (state == S_CALC) len <= len_calc;

      case ({ar_hs, rlast_hs})
        2'b10:   outstanding <= outstanding + OUT_W'(1);
        2'b01:   outstanding <= outstanding - OUT_W'(1);
        default: outstanding <= outstanding;
      endcase

      if (start_ok)  beat_cnt <= '0;
      else if (r_hs) beat_cnt <= m_axis_tlast ? '0 : beat_cnt + 32'd1;

      if (start_ok)                          err_r <= 1'b0;
      else if (r_hs && m_axi_rresp != 2'b00) err_r <= 1'b1;
    end
  end

  assign m_axi_araddr  = addr;
  assign m_axi_arlen   = 8'(len - 9'd1);
  assign m_axi_rready  = m_axis_tready;
  assign m_axis_tvalid = m_axi_rvalid;
  assign m_axis_tdata  = m_axi_rdata;
  assign m_axis_tlast  = (beat_cnt == row_beats - 32'd1);
  assign ctrl_err      = err_r;

`ifdef HBM_RD_PERF_CNT_EN
  logic [31:0] cyc_cnt, stall_cnt;

  always_ff @(posedge aclk) begin
    if (areset || start_ok) begin
      cyc_cnt   <= '0;
      stall_cnt <= '0;
    end else begin
      if (ctrl_busy && cyc_cnt != '1)                       cyc_cnt   <= cyc_cnt + 32'd1;
      if (m_axi_rvalid && !m_axis_tready && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign stat_cycles = cyc_cnt;
  assign stat_stalls = stall_cnt;
`else
  assign stat_cycles = '0;
  assign stat_stalls = '0;
`endif

endmodule

// File: tb/tb_hbm_strided_read_master.sv
// Directed bench for hbm_strided_read_master: behavioural AXI slave returning address-tagged data,
// stream/AR logs, and per-scenario tasks with hand-computed expectations.
module tb_hbm_strided_read_master;
  localparam int AW = 64;
  localparam int DW = 512;
  localparam int RW = 16;

  logic aclk = 1'b0;
  logic areset;
  logic ctrl_start;
  logic [AW-1:0] ctrl_addr, ctrl_stride;
  logic [31:0] ctrl_row_bytes;
  logic [RW-1:0] ctrl_num_rows;
  logic ctrl_busy, ctrl_done, ctrl_err;
  logic m_axi_arvalid, m_axi_arready;
  logic [AW-1:0] m_axi_araddr;
  logic [7:0] m_axi_arlen;
  logic m_axi_rvalid, m_axi_rready, m_axi_rlast;
  logic [DW-1:0] m_axi_rdata;
  logic [1:0] m_axi_rresp;
  logic m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [DW-1:0] m_axis_tdata;
  logic [31:0] stat_cycles, stat_stalls;

  hbm_strided_read_master #(
    .C_M_AXI_ADDR_WIDTH(AW), .C_M_AXI_DATA_WIDTH(DW), .C_BURST_LEN(64),
    .C_MAX_OUTSTANDING(2), .C_ROWS_WIDTH(RW)
  ) dut (
    .aclk(aclk), .areset(areset), .ctrl_start(ctrl_start), .ctrl_addr(ctrl_addr),
    .ctrl_row_bytes(ctrl_row_bytes), .ctrl_stride(ctrl_stride), .ctrl_num_rows(ctrl_num_rows),
    .ctrl_busy(ctrl_busy), .ctrl_done(ctrl_done), .ctrl_err(ctrl_err),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready), .m_axi_araddr(m_axi_araddr),
    .m_axi_arlen(m_axi_arlen), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
    .m_axis_tlast(m_axis_tlast), .stat_cycles(stat_cycles), .stat_stalls(stat_stalls)
  );

  always #5 aclk = ~aclk;

  // Slave model: accepted ARs queue up; each beat carries its own byte address replicated.
  logic          ar_en, r_en;
  int            err_at;
  logic [AW-1:0] fifo_addr [0:63];
  logic [7:0]    fifo_len  [0:63];
  logic [5:0]    wp = '0, rp = '0;
  logic [7:0]    rbeat = '0;
  logic [AW-1:0] cur_addr;

  assign m_axi_arready = ar_en;
  assign cur_addr      = fifo_addr[rp] + (AW'(rbeat) << 6);
  assign m_axi_rvalid  = r_en && (wp != rp);
  assign m_axi_rdata   = {8{cur_addr}};
  assign m_axi_rlast   = (rbeat == fifo_len[rp]);

  // Logs, cumulative across tests; each test remembers its starting indices.
  logic [AW-1:0] log_addr [0:63];
  logic [7:0]    log_len  [0:63];
  int            log_cyc  [0:63];
  logic [DW-1:0] beat_data [0:1023];
  logic          beat_last [0:1023];
  int            beat_cyc  [0:1023];
  int n_ar = 0, n_beat = 0, n_done = 0, stall_cnt = 0, done_cyc = 0, cyc = 0;

  assign m_axi_rresp = (n_beat == err_at) ? 2'b10 : 2'b00;

  always @(posedge aclk) begin
    cyc <= cyc + 1;
    if (m_axi_arvalid && m_axi_arready) begin
      fifo_addr[wp]  <= m_axi_araddr;
      fifo_len[wp]   <= m_axi_arlen;
      wp             <= wp + 6'd1;
      log_addr[n_ar] <= m_axi_araddr;
      log_len[n_ar]  <= m_axi_arlen;
      log_cyc[n_ar]  <= cyc;
      n_ar           <= n_ar + 1;
    end
    if (m_axi_rvalid && m_axi_rready) begin
      if (m_axi_rlast) begin rp <= rp + 6'd1; rbeat <= '0; end
      else rbeat <= rbeat + 8'd1;
    end
    if (m_axis_tvalid && m_axis_tready) begin
      beat_data[n_beat] <= m_axis_tdata;
      beat_last[n_beat] <= m_axis_tlast;
      beat_cyc[n_beat]  <= cyc;
      n_beat            <= n_beat + 1;
    end
    if (m_axi_rvalid && !m_axis_tready) stall_cnt <= stall_cnt + 1;
    if (ctrl_done) begin done_cyc <= cyc; n_done <= n_done + 1; end
  end

  int total = 0, passed = 0;
  int start_cyc, ar_base, beat_base, done0, stall0;

  function automatic logic [AW-1:0] exp_addr(input logic [AW-1:0] base, input logic [AW-1:0] stride,
                                             input int rb, input int k);
    return base + AW'(k / rb) * stride + AW'((k % rb) * 64);
  endfunction

  task automatic do_start(input logic [AW-1:0] a, input logic [31:0] rb, input logic [AW-1:0] st,
                          input logic [RW-1:0] nr);
    @(negedge aclk);
    ctrl_addr = a; ctrl_row_bytes = rb; ctrl_stride = st; ctrl_num_rows = nr; ctrl_start = 1'b1;
    start_cyc = cyc; done0 = n_done; ar_base = n_ar; beat_base = n_beat; stall0 = stall_cnt;
    @(negedge aclk);
    ctrl_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge aclk);
      if (n_done != done0) ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    areset = 1'b1;
    repeat (4) @(negedge aclk);
    areset = 1'b0;
    @(negedge aclk);
    total++; if (m_axi_arvalid !== 1'b0) $display("FAIL reset_arvalid: got %b want 0", m_axi_arvalid); else passed++;
    total++; if (ctrl_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", ctrl_busy); else passed++;
    total++; if (ctrl_done !== 1'b0) $display("FAIL reset_done: got %b want 0", ctrl_done); else passed++;
    total++; if (ctrl_err !== 1'b0) $display("FAIL reset_err: got %b want 0", ctrl_err); else passed++;
    total++; if ({stat_cycles, stat_stalls} !== 64'd0) $display("FAIL reset_stats: got %h/%h want 0/0", stat_cycles, stat_stalls); else passed++;
  endtask

  task automatic test_two_bursts;
    logic [AW-1:0] ea [2] = '{64'h1000, 64'h2000};
    bit ok; int bad, badl;
    do_start(64'h1000, 32'd8192, 64'd0, 16'd1);
    wait_done(3000, ok);
    total++; if (!ok) $display("FAIL basic_done: no ctrl_done within 3000 cycles"); else passed++;
    total++; if (n_ar - ar_base !== 2) $display("FAIL basic_ar_count: got %0d want 2", n_ar - ar_base); else passed++;
    for (int i = 0; i < 2; i++) begin
      total++;
      if ({log_addr[ar_base+i], log_len[ar_base+i]} !== {ea[i], 8'd63})
        $display("FAIL basic_ar%0d: got %h/%0d want %h/63", i, log_addr[ar_base+i], log_len[ar_base+i], ea[i]);
      else passed++;
    end
    total++; if (n_beat - beat_base !== 128) $display("FAIL basic_beats: got %0d want 128", n_beat - beat_base); else passed++;
    bad = 0; badl = 0;
    for (int k = 0; k < 128; k++) begin
      if (beat_data[beat_base+k] !== {8{exp_addr(64'h1000, 64'd0, 128, k)}}) bad++;
      if (beat_last[beat_base+k] !== (k == 127)) badl++;
    end
    total++; if (bad !== 0) $display("FAIL basic_data: %0d bad beats want 0", bad); else passed++;
    total++; if (badl !== 0) $display("FAIL basic_tlast: %0d bad tlast want 0", badl); else passed++;
    total++; if (done_cyc - beat_cyc[beat_base+127] !== 1) $display("FAIL basic_done_lat: got %0d want 1", done_cyc - beat_cyc[beat_base+127]); else passed++;
    total++; if (ctrl_err !== 1'b0) $display("FAIL basic_err: got %b want 0", ctrl_err); else passed++;
  endtask

  task automatic test_4k_split;
    logic [AW-1:0] ea [2] = '{64'h0F80, 64'h1000};
    bit ok; int bad, badl;
    do_start(64'h0F80, 32'd256, 64'd0, 16'd1);
    @(negedge aclk);
    total++; if (ctrl_busy !== 1'b1) $display("FAIL split_busy: got %b want 1", ctrl_busy); else passed++;
    ctrl_addr = 64'h8000; ctrl_row_bytes = 32'd4096; ctrl_num_rows = 16'd3; ctrl_start = 1'b1;
    @(negedge aclk);
    ctrl_start = 1'b0;
    wait_done(500, ok);
    total++; if (!ok) $display("FAIL split_done: no ctrl_done within 500 cycles"); else passed++;
    repeat (10) @(negedge aclk);
    total++; if (n_ar - ar_base !== 2) $display("FAIL split_ar_count: got %0d want 2", n_ar - ar_base); else passed++;
    for (int i = 0; i < 2; i++) begin
      total++;
      if ({log_addr[ar_base+i], log_len[ar_base+i]} !== {ea[i], 8'd1})
        $display("FAIL split_ar%0d: got %h/%0d want %h/1", i, log_addr[ar_base+i], log_len[ar_base+i], ea[i]);
      else passed++;
    end
    bad = 0; badl = 0;
    for (int k = 0; k < 4; k++) begin
      if (beat_data[beat_base+k] !== {8{exp_addr(64'h0F80, 64'd0, 4, k)}}) bad++;
      if (beat_last[beat_base+k] !== (k == 3)) badl++;
    end
    total++; if (n_beat - beat_base !== 4) $display("FAIL split_beats: got %0d want 4", n_beat - beat_base); else passed++;
    total++; if (bad !== 0) $display("FAIL split_data: %0d bad beats want 0", bad); else passed++;
    total++; if (badl !== 0) $display("FAIL split_tlast: %0d bad tlast want 0", badl); else passed++;
  endtask

  task automatic test_stride_rows;
    logic [AW-1:0] ea [3] = '{64'h0, 64'h10000, 64'h20000};
    bit ok; int bad, badl;
    do_start(64'h0, 32'd100, 64'h10000, 16'd3);
    wait_done(500, ok);
    total++; if (!ok) $display("FAIL stride_done: no ctrl_done within 500 cycles"); else passed++;
    total++; if (n_ar - ar_base !== 3) $display("FAIL stride_ar_count: got %0d want 3", n_ar - ar_base); else passed++;
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({log_addr[ar_base+i], log_len[ar_base+i]} !== {ea[i], 8'd1})
        $display("FAIL stride_ar%0d: got %h/%0d want %h/1", i, log_addr[ar_base+i], log_len[ar_base+i], ea[i]);
      else passed++;
    end
    bad = 0; badl = 0;
    for (int k = 0; k < 6; k++) begin
      if (beat_data[beat_base+k] !== {8{exp_addr(64'h0, 64'h10000, 2, k)}}) bad++;
      if (beat_last[beat_base+k] !== (k % 2 == 1)) badl++;
    end
    total++; if (n_beat - beat_base !== 6) $display("FAIL stride_beats: got %0d want 6", n_beat - beat_base); else passed++;
    total++; if (bad !== 0) $display("FAIL stride_data: %0d bad beats want 0", bad); else passed++;
    total++; if (badl !== 0) $display("FAIL stride_tlast: %0d bad tlast want 0", badl); else passed++;
  endtask

  task automatic test_outstanding_cap;
    bit ok; int bad, badl;
    r_en = 1'b0;
    do_start(64'h0, 32'd16384, 64'd0, 16'd1);
    repeat (30) @(negedge aclk);
    total++; if (n_ar - ar_base !== 2) $display("FAIL cap_ar_count: got %0d want 2", n_ar - ar_base); else passed++;
    total++; if (m_axi_arvalid !== 1'b0) $display("FAIL cap_arvalid: got %b want 0", m_axi_arvalid); else passed++;
    r_en = 1'b1;
    wait_done(2000, ok);
    total++; if (!ok) $display("FAIL cap_done: no ctrl_done within 2000 cycles"); else passed++;
    total++; if (n_ar - ar_base !== 4) $display("FAIL cap_ar_total: got %0d want 4", n_ar - ar_base); else passed++;
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({log_addr[ar_base+i], log_len[ar_base+i]} !== {AW'(i) * 64'h1000, 8'd63})
        $display("FAIL cap_ar%0d: got %h/%0d want %h/63", i, log_addr[ar_base+i], log_len[ar_base+i], AW'(i) * 64'h1000);
      else passed++;
    end
    total++;
    if (log_cyc[ar_base+2] <= beat_cyc[beat_base+63])
      $display("FAIL cap_third_ar: AR at cycle %0d, first rlast at %0d, want AR later", log_cyc[ar_base+2], beat_cyc[beat_base+63]);
    else passed++;
    bad = 0; badl = 0;
    for (int k = 0; k < 256; k++) begin
      if (beat_data[beat_base+k] !== {8{exp_addr(64'h0, 64'd0, 256, k)}}) bad++;
      if (beat_last[beat_base+k] !== (k == 255)) badl++;
    end
    total++; if (bad !== 0) $display("FAIL cap_data: %0d bad beats want 0", bad); else passed++;
    total++; if (badl !== 0) $display("FAIL cap_tlast: %0d bad tlast want 0", badl); else passed++;
  endtask

  task automatic test_backpressure_err;
    bit ok; int bad, badl;
    err_at = n_beat + 2;
    do_start(64'h3000, 32'd640, 64'd0, 16'd1);
    for (int i = 0; i < 1000 && !ok; i++) begin
      @(negedge aclk);
      m_axis_tready = 1'($urandom_range(0, 1));
      if (n_done != done0) ok = 1'b1;
    end
    m_axis_tready = 1'b1;
    err_at = -1;
    total++; if (!ok) $display("FAIL bp_done: no ctrl_done within 1000 cycles"); else passed++;
    total++;
    if ({log_addr[ar_base], log_len[ar_base]} !== {64'h3000, 8'd9})
      $display("FAIL bp_ar: got %h/%0d want 3000/9", log_addr[ar_base], log_len[ar_base]);
    else passed++;
    bad = 0; badl = 0;
    for (int k = 0; k < 10; k++) begin
      if (beat_data[beat_base+k] !== {8{exp_addr(64'h3000, 64'd0, 10, k)}}) bad++;
      if (beat_last[beat_base+k] !== (k == 9)) badl++;
    end
    total++; if (n_beat - beat_base !== 10) $display("FAIL bp_beats: got %0d want 10", n_beat - beat_base); else passed++;
    total++; if (bad !== 0) $display("FAIL bp_data: %0d bad beats want 0", bad); else passed++;
    total++; if (badl !== 0) $display("FAIL bp_tlast: %0d bad tlast want 0", badl); else passed++;
    repeat (5) @(negedge aclk);
    total++; if (ctrl_err !== 1'b1) $display("FAIL bp_err_sticky: got %b want 1", ctrl_err); else passed++;
`ifdef HBM_RD_PERF_CNT_EN
    total++; if (stat_stalls !== 32'(stall_cnt - stall0)) $display("FAIL bp_stalls: got %0d want %0d", stat_stalls, stall_cnt - stall0); else passed++;
    total++; if (stat_cycles !== 32'(done_cyc - start_cyc)) $display("FAIL bp_cycles: got %0d want %0d", stat_cycles, done_cyc - start_cyc); else passed++;
`else
    total++; if ({stat_cycles, stat_stalls} !== 64'd0) $display("FAIL bp_stats_off: got %h/%h want 0/0", stat_cycles, stat_stalls); else passed++;
`endif
  endtask

  task automatic test_empty;
    bit ok;
    do_start(64'h5000, 32'd256, 64'd0, 16'd0);
    total++; if (ctrl_err !== 1'b0) $display("FAIL empty_err_clear: got %b want 0", ctrl_err); else passed++;
    wait_done(50, ok);
    total++; if (!ok) $display("FAIL empty_done: no ctrl_done within 50 cycles"); else passed++;
    total++; if (done_cyc - start_cyc !== 2) $display("FAIL empty_rows_lat: got %0d want 2", done_cyc - start_cyc); else passed++;
    do_start(64'h5000, 32'd0, 64'd0, 16'd2);
    wait_done(50, ok);
    total++; if (!ok) $display("FAIL empty_bytes_done: no ctrl_done within 50 cycles"); else passed++;
    total++; if (done_cyc - start_cyc !== 2) $display("FAIL empty_bytes_lat: got %0d want 2", done_cyc - start_cyc); else passed++;
    total++; if (n_ar - ar_base !== 0) $display("FAIL empty_no_ar: got %0d ARs want 0", n_ar - ar_base); else passed++;
  endtask

  initial begin
    ctrl_start = 1'b0; ctrl_addr = '0; ctrl_row_bytes = '0; ctrl_stride = '0; ctrl_num_rows = '0;
    m_axis_tready = 1'b1; ar_en = 1'b1; r_en = 1'b1; err_at = -1;
    test_reset;
    test_two_bursts;
    test_4k_split;
    test_stride_rows;
    test_outstanding_cap;
    test_backpressure_err;
    test_empty;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
